// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   ST_IDLE/ST_RUN/ST_DONE : FSM state encoding
//   state_t                : enum built on that encoding
//   clog2                  : ceil(log2(value)), used to size the digit counter
package cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_digit_compare.sv
// Combinational unsigned compare of one digit.
//   x, y  : DIGIT_W-bit digits
//   dgt   : x > y
//   dlt   : x < y
module digit_compare #(
  parameter int DIGIT_W = 2
) (
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  output logic               dgt,
  output logic               dlt
);

  assign dgt = (x > y);
  assign dlt = (x < y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands MSB-first,
// DIGIT_W bits per clock, unsigned or two's-complement (chosen per operation).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, accepted in IDLE or DONE
//   signed_mode, a, b   : operation inputs, captured with start
//   busy                : digits being compared
//   done                : one-cycle pulse, gt/lt/eq updated this cycle
//   gt, lt, eq          : registered result, held until the next done
// Build option: define CMP_EARLY_EXIT_EN to leave RUN as soon as the first
// differing digit is found (results unchanged, only timing differs).
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | no operation in flight, waiting for start
// RUN   | comparing one digit per clock, MSB digit first
// DONE  | one-cycle result strobe; start here chains a new compare
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sa, sb;
  logic [CNT_W-1:0]   cnt;
  logic               decided, res_gt;
  logic               dgt, dlt, differ;
  logic               capture, finish;
  logic               fin_decided, fin_gt;

  digit_compare #(.DIGIT_W(DIGIT_W)) u_digit (
    .x   (sa[WIDTH-1 -: DIGIT_W]),
    .y   (sb[WIDTH-1 -: DIGIT_W]),
    .dgt (dgt),
    .dlt (dlt)
  );

  assign differ = dgt | dlt;

  // Result as it stands after the current digit, so the final digit's outcome
  // is folded in on the same edge that enters DONE.
  assign fin_decided = decided | differ;
  assign fin_gt      = decided ? res_gt : dgt;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          capture   = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt == '0) finish = 1'b1;
`ifdef CMP_EARLY_EXIT_EN
        if (!decided && differ) finish = 1'b1;
`endif
        if (finish) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          capture   = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      res_gt  <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        // Flipping both sign bits maps two's-complement order onto unsigned
        // order, so the digit datapath never needs to know the mode.
        sa      <= signed_mode ? (a ^ MSB_MASK) : a;
        sb      <= signed_mode ? (b ^ MSB_MASK) : b;
        cnt     <= CNT_W'(N - 1);
        decided <= 1'b0;
      end else if (state == S_RUN) begin
        if (!decided && differ) begin
          decided <= 1'b1;
          res_gt  <= dgt;
        end
        sa  <= sa << DIGIT_W;
        sb  <= sb << DIGIT_W;
        cnt <= cnt - 1'b1;
      end
      if (finish) begin
        gt <= fin_decided & fin_gt;
        lt <= fin_decided & ~fin_gt;
        eq <= ~fin_decided;
      end
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
module tb_serial_magnitude_comparator;

  localparam int WIDTH = 8;
  localparam int DW    = 2;
  localparam int N     = WIDTH / DW;

  logic             clk = 1'b0;
  logic             rst, start, signed_mode;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, gt, lt, eq;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .gt          (gt),
    .lt          (lt),
    .eq          (eq)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [2:0]       exp;   // {gt, lt, eq}
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic s);
    int vx, vy;
    vx = s ? int'($signed(x)) : int'(x);
    vy = s ? int'($signed(y)) : int'(y);
    return {vx > vy, vx < vy, vx == vy};
  endfunction

  // Cycle (counted from the start-sampling cycle 0) in which done is expected.
  function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef CMP_EARLY_EXIT_EN
    for (int d = 0; d < N; d++) begin
      if (x[WIDTH-1-d*DW -: DW] != y[WIDTH-1-d*DW -: DW]) return d + 2;
    end
`endif
    return N + 1;
  endfunction

  // Called just after a negedge. Launches one operation and follows it to its
  // done cycle, returning at that cycle's negedge so the next start can be
  // chained straight into DONE. poke re-asserts start with other operands
  // during RUN to show it is ignored.
  task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic os,
                        input bit poke, input string nm);
    int         lat;
    logic [2:0] f;
    lat = model_lat(oa, ob);
    f   = model_flags(oa, ob, os);
    a = oa; b = ob; signed_mode = os; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      check({nm, " busy"}, {31'd0, busy}, {31'd0, (k < lat)});
      check({nm, " done"}, {31'd0, done}, {31'd0, (k == lat)});
      if (k == lat) begin
        check({nm, " flags"}, {29'd0, gt, lt, eq}, {29'd0, f});
        check({nm, " onehot"}, $countones({gt, lt, eq}), 1);
        break;
      end
      if (done) break;
      if (poke && k <= 3) begin
        start = 1'b1; a = ~oa; b = oa; signed_mode = ~os;
      end else begin
        start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); signed_mode = 1'($urandom);
      end
    end
  endtask

  task automatic idle(input int n, input string nm);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({nm, " idle done"}, {31'd0, done}, 0);
      check({nm, " idle busy"}, {31'd0, busy}, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'hA5, 8'h3C, 1'b0, 3'b100};
    tbl[1] = '{8'h7E, 8'h7E, 1'b1, 3'b001};
    tbl[2] = '{8'h7E, 8'h7E, 1'b0, 3'b001};
    tbl[3] = '{8'h80, 8'h01, 1'b1, 3'b010};
    tbl[4] = '{8'h80, 8'h01, 1'b0, 3'b100};
    tbl[5] = '{8'h1C, 8'h1D, 1'b0, 3'b010};
    tbl[6] = '{8'h40, 8'h00, 1'b0, 3'b100};
    tbl[7] = '{8'hFF, 8'h00, 1'b1, 3'b010};
    tbl[8] = '{8'h7F, 8'h80, 1'b1, 3'b100};
    tbl[9] = '{8'h00, 8'h00, 1'b1, 3'b001};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, busy}, 0);
    check("rst done", {31'd0, done}, 0);
    check("rst flags", {29'd0, gt, lt, eq}, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, 1'b0, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d table", i), {29'd0, gt, lt, eq}, {29'd0, tbl[i].exp});
      idle(1, "tbl");
    end

    // start pulsed during RUN: ignored, single done, no second one
    run_op(8'h7E, 8'h7E, 1'b0, 1'b1, "poke");
    idle(3, "poke");

    // reset in cycle 2 of an operation
    a = 8'hA5; b = 8'h3C; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("abort busy", {31'd0, busy}, 0);
    check("abort done", {31'd0, done}, 0);
    check("abort flags", {29'd0, gt, lt, eq}, 0);
    rst = 1'b0;
    idle(6, "abort");
    run_op(8'h1C, 8'h1D, 1'b0, 1'b0, "fresh");
    idle(1, "fresh");

    // back-to-back random operations, each start issued in the previous done cycle
    for (int i = 0; i < 3000; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
      run_op(ra, rb, 1'($urandom), 1'b0, "rand");
    end
    idle(2, "tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
